// File: rtl/baseline_calibrator_pkg.sv
// Shared DSP configuration (dsp_config) for the RFDC H-gain path.
// Sample geometry and the reset baseline used by the calibration blocks.
package baseline_calibrator_pkg;

    localparam int ADC_RESOLUTION_WIDTH = 12;
    localparam int SAMPLE_WIDTH         = 16;
    localparam int SAMPLE_NUM_PER_CLK   = 8;
    localparam int RFDC_TDATA_WIDTH     = SAMPLE_WIDTH * SAMPLE_NUM_PER_CLK;
    localparam int SAMPLE_LSB_PAD       = SAMPLE_WIDTH - ADC_RESOLUTION_WIDTH;
    localparam int LANE_SUM_WIDTH       = ADC_RESOLUTION_WIDTH + 3;
    localparam int BASELINE_WIDTH       = ADC_RESOLUTION_WIDTH + 1;

    localparam logic signed [BASELINE_WIDTH-1:0] RESET_BASELINE = -13'sd1024;

endpackage

// File: rtl/baseline_calibrator_lane_sum.sv
// Combinational signed adder tree: sums the 8 left-justified 12-bit samples
// of one RFDC beat into a 15-bit result.
module lane_sum
    import baseline_calibrator_pkg::*;
(
    input  logic        [RFDC_TDATA_WIDTH-1:0] tdata,
    output logic signed [LANE_SUM_WIDTH-1:0]   sum
);

    logic signed [ADC_RESOLUTION_WIDTH-1:0] lane_s [SAMPLE_NUM_PER_CLK];
    logic signed [ADC_RESOLUTION_WIDTH:0]   lvl1_s [4];
    logic signed [ADC_RESOLUTION_WIDTH+1:0] lvl2_s [2];
    logic        [SAMPLE_LSB_PAD*SAMPLE_NUM_PER_CLK-1:0] pad_bits_s;
    logic                                   unused_pad_s;

    for (genvar i = 0; i < SAMPLE_NUM_PER_CLK; i++) begin : g_lane
        assign lane_s[i] = tdata[i*SAMPLE_WIDTH+SAMPLE_LSB_PAD +: ADC_RESOLUTION_WIDTH];
        assign pad_bits_s[i*SAMPLE_LSB_PAD +: SAMPLE_LSB_PAD] = tdata[i*SAMPLE_WIDTH +: SAMPLE_LSB_PAD];
    end

    // The low pad nibble of each lane carries no sample information.
    assign unused_pad_s = ^pad_bits_s;

    // Three-level tree, each level one bit wider so no sum can wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1_s[i] = {lane_s[2*i][ADC_RESOLUTION_WIDTH-1], lane_s[2*i]}
                      + {lane_s[2*i+1][ADC_RESOLUTION_WIDTH-1], lane_s[2*i+1]};
        end
        for (int j = 0; j < 2; j++) begin
            lvl2_s[j] = {lvl1_s[2*j][ADC_RESOLUTION_WIDTH], lvl1_s[2*j]}
                      + {lvl1_s[2*j+1][ADC_RESOLUTION_WIDTH], lvl1_s[2*j+1]};
        end
        sum = {lvl2_s[0][ADC_RESOLUTION_WIDTH+1], lvl2_s[0]}
            + {lvl2_s[1][ADC_RESOLUTION_WIDTH+1], lvl2_s[1]};
    end

endmodule

// File: rtl/baseline_calibrator.sv
// Measures the mean H-gain ADC level over a window of beats and hands it to
// the DSP stage as its baseline; a manual baseline can also be loaded directly.
module baseline_calibrator
    import baseline_calibrator_pkg::*;
#(
    parameter int LOG2_ACC_BEATS = 4,
    parameter int FLUSH_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic                             START,
    input  logic                             MANUAL_SET,
    input  logic signed [BASELINE_WIDTH-1:0] MANUAL_BASELINE,
    input  logic        [RFDC_TDATA_WIDTH-1:0] H_S_AXIS_TDATA,
    input  logic                             H_S_AXIS_TVALID,
    output logic                             SET_CONFIG,
    output logic signed [BASELINE_WIDTH-1:0] H_GAIN_BASELINE,
    output logic                             BUSY,
    output logic                             DONE,
    output logic                             CAL_ERROR
);

    localparam int ACC_W     = ADC_RESOLUTION_WIDTH + 3 + LOG2_ACC_BEATS;
    localparam int SHIFT     = 3 + LOG2_ACC_BEATS;
    localparam int ACC_BEATS = 1 << LOG2_ACC_BEATS;
    localparam int CNT_W     = ((ACC_BEATS > FLUSH_CYCLES) ? LOG2_ACC_BEATS : $clog2(FLUSH_CYCLES)) + 1;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_APPLY   = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t                           state_r;
    logic        [CNT_W-1:0]          beat_cnt_r;
    logic        [TO_W-1:0]           timeout_cnt_r;
    logic signed [ACC_W-1:0]          acc_r;
    logic signed [BASELINE_WIDTH-1:0] baseline_r;
    logic                             set_config_r;
    logic                             manual_pending_r;
    logic                             busy_r;
    logic                             done_r;
    logic                             cal_error_r;
    logic signed [LANE_SUM_WIDTH-1:0] beat_sum_s;
    logic signed [BASELINE_WIDTH-1:0] mean_s;
    logic                             timeout_hit_s;

    lane_sum u_lane_sum (
        .tdata (H_S_AXIS_TDATA),
        .sum   (beat_sum_s)
    );

    // The window mean always fits in 13 bits, so truncating the floor-shifted sum is exact.
    assign mean_s        = BASELINE_WIDTH'(acc_r >>> SHIFT);
    assign timeout_hit_s = (timeout_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Calibration sequencer with all outputs registered.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r          <= ST_IDLE;
            beat_cnt_r       <= '0;
            timeout_cnt_r    <= '0;
            acc_r            <= '0;
            baseline_r       <= RESET_BASELINE;
            set_config_r     <= 1'b0;
            manual_pending_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            cal_error_r      <= 1'b0;
        end else begin
            set_config_r     <= manual_pending_r;
            manual_pending_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r       <= ST_FLUSH;
                        busy_r        <= 1'b1;
                        beat_cnt_r    <= '0;
                        timeout_cnt_r <= '0;
                        acc_r         <= '0;
                        done_r        <= 1'b0;
                        cal_error_r   <= 1'b0;
                    end else if (MANUAL_SET && !manual_pending_r) begin
                        // Strobe follows a cycle later so the baseline is settled under it.
                        baseline_r       <= MANUAL_BASELINE;
                        manual_pending_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FLUSH, ST_ACCUM: begin
                    if (H_S_AXIS_TVALID) begin
                        timeout_cnt_r <= '0;
                        if (state_r == ST_FLUSH) begin
                            if (beat_cnt_r == CNT_W'(FLUSH_CYCLES - 1)) begin
                                beat_cnt_r <= '0;
                                state_r    <= ST_ACCUM;
                            end else begin
                                beat_cnt_r <= beat_cnt_r + 1'b1;
                            end
                        end else begin
                            acc_r <= acc_r + ACC_W'(beat_sum_s);
                            if (beat_cnt_r == CNT_W'(ACC_BEATS - 1)) begin
                                beat_cnt_r <= '0;
                                state_r    <= ST_COMPUTE;
                            end else begin
                                beat_cnt_r <= beat_cnt_r + 1'b1;
                            end
                        end
                    end else if (timeout_hit_s) begin
                        timeout_cnt_r <= timeout_cnt_r + 1'b1;
                        state_r       <= ST_ERROR;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    baseline_r <= mean_s;
                    state_r    <= ST_APPLY;
                end
                ST_APPLY: begin
                    set_config_r <= 1'b1;
                    done_r       <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                ST_ERROR: begin
                    cal_error_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign SET_CONFIG      = set_config_r;
    assign H_GAIN_BASELINE = baseline_r;
    assign BUSY            = busy_r;
    assign DONE            = done_r;
    assign CAL_ERROR       = cal_error_r;

endmodule

// File: tb/tb_baseline_calibrator.sv
// Directed, table-driven bench for baseline_calibrator: calibration vectors
// with hand-computed means plus timeout, manual-load and reset sequences.
module tb_baseline_calibrator;
    import baseline_calibrator_pkg::*;

    logic               ACLK = 1'b0;
    logic               ARESET;
    logic               START;
    logic               MANUAL_SET;
    logic signed [12:0] MANUAL_BASELINE;
    logic [127:0]       H_S_AXIS_TDATA;
    logic               H_S_AXIS_TVALID;
    logic               SET_CONFIG;
    logic signed [12:0] H_GAIN_BASELINE;
    logic               BUSY;
    logic               DONE;
    logic               CAL_ERROR;

    baseline_calibrator dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .START           (START),
        .MANUAL_SET      (MANUAL_SET),
        .MANUAL_BASELINE (MANUAL_BASELINE),
        .H_S_AXIS_TDATA  (H_S_AXIS_TDATA),
        .H_S_AXIS_TVALID (H_S_AXIS_TVALID),
        .SET_CONFIG      (SET_CONFIG),
        .H_GAIN_BASELINE (H_GAIN_BASELINE),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .CAL_ERROR       (CAL_ERROR)
    );

    always #5 ACLK = ~ACLK;

    int   checks   = 0;
    int   failures = 0;
    int   exp_sc   = 0;
    int   sc_count = 0;
    int   sc_consec = 0;
    logic sc_prev  = 1'b0;

    // Count SET_CONFIG pulses and back-to-back highs over the whole run.
    always @(negedge ACLK) begin
        if (SET_CONFIG === 1'b1) begin
            sc_count <= sc_count + 1;
            if (sc_prev) sc_consec <= sc_consec + 1;
        end
        sc_prev <= (SET_CONFIG === 1'b1);
    end

    typedef struct {
        logic signed [11:0] a;      // even lanes
        logic signed [11:0] b;      // odd lanes
        logic [3:0]         nib;    // pad nibble, must be ignored
        int                 gap;    // idle cycles before each beat
        bit                 poke;   // fire START+MANUAL_SET mid-ACCUM
        logic signed [12:0] exp;
        string              name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [127:0] beat(input logic signed [11:0] a, input logic signed [11:0] b,
                                          input logic [3:0] nib);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = (i % 2 == 0) ? {a, nib} : {b, nib};
        return w;
    endfunction

    task automatic calibrate(input vec_t v);
        START = 1'b1;
        step();
        START = 1'b0;
        check({v.name, "_busy_start"}, BUSY, 1);
        check({v.name, "_done_clr"}, DONE, 0);
        check({v.name, "_err_clr"}, CAL_ERROR, 0);
        for (int bi = 0; bi < 20; bi++) begin
            for (int g = 0; g < v.gap; g++) begin
                H_S_AXIS_TVALID = 1'b0;
                step();
            end
            H_S_AXIS_TVALID = 1'b1;
            H_S_AXIS_TDATA  = (bi < 4) ? beat(12'sh7FF, 12'sh7FF, 4'hA) : beat(v.a, v.b, v.nib);
            if (v.poke && bi == 10) begin
                MANUAL_SET      = 1'b1;
                MANUAL_BASELINE = -13'sd77;
                START           = 1'b1;
            end
            step();
            MANUAL_SET = 1'b0;
            START      = 1'b0;
        end
        H_S_AXIS_TVALID = 1'b0;
        H_S_AXIS_TDATA  = '0;
        check({v.name, "_busy_n"}, BUSY, 1);
        check({v.name, "_sc_n"}, SET_CONFIG, 0);
        step();
        check({v.name, "_baseline_n1"}, H_GAIN_BASELINE, v.exp);
        check({v.name, "_sc_n1"}, SET_CONFIG, 0);
        step();
        check({v.name, "_sc_n2"}, SET_CONFIG, 1);
        check({v.name, "_baseline_n2"}, H_GAIN_BASELINE, v.exp);
        check({v.name, "_done"}, DONE, 1);
        check({v.name, "_busy_idle"}, BUSY, 0);
        step();
        check({v.name, "_sc_n3"}, SET_CONFIG, 0);
        exp_sc++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sc"}, SET_CONFIG, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_err"}, CAL_ERROR, 0);
        check({tag, "_baseline"}, H_GAIN_BASELINE, -1024);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{12'sd100,   12'sd100,   4'h0, 0, 1'b0, 13'sd100,   "all100"};
        vecs[1] = '{-12'sd3,    -12'sd4,    4'h0, 0, 1'b0, -13'sd4,    "alt_m3_m4"};
        vecs[2] = '{12'sd100,   12'sd100,   4'h0, 3, 1'b0, 13'sd100,   "gap3"};
        vecs[3] = '{12'sd100,   12'sd100,   4'hF, 0, 1'b0, 13'sd100,   "pad_noise"};
        vecs[4] = '{12'sd2047,  12'sd2047,  4'h5, 1, 1'b0, 13'sd2047,  "max"};
        vecs[5] = '{-12'sd2048, -12'sd2048, 4'h0, 0, 1'b0, -13'sd2048, "min"};
        vecs[6] = '{12'sd1,     12'sd0,     4'h0, 0, 1'b1, 13'sd0,     "half_pos"};
        vecs[7] = '{-12'sd1,    12'sd0,     4'h0, 0, 1'b1, -13'sd1,    "half_neg"};

        ARESET = 1'b1; START = 1'b0; MANUAL_SET = 1'b0; MANUAL_BASELINE = '0;
        H_S_AXIS_TDATA = '0; H_S_AXIS_TVALID = 1'b0;
        step();
        step();
        ARESET = 1'b0;
        check_reset_state("reset");

        // Stream stalls completely: abort after TIMEOUT_CYCLES idle clocks.
        START = 1'b1;
        step();
        START = 1'b0;
        cyc = 0;
        while (CAL_ERROR !== 1'b1 && cyc < 1200) begin
            step();
            cyc++;
        end
        check("timeout_cycles", cyc, 1025);
        check("timeout_busy", BUSY, 0);
        check("timeout_baseline", H_GAIN_BASELINE, -1024);
        check("timeout_done", DONE, 0);
        check("timeout_no_sc", sc_count, 0);
        step();
        step();
        check("timeout_sticky", CAL_ERROR, 1);

        // Manual baseline load in IDLE.
        MANUAL_SET = 1'b1;
        MANUAL_BASELINE = -13'sd200;
        step();
        MANUAL_SET = 1'b0;
        check("manual_baseline", H_GAIN_BASELINE, -200);
        check("manual_sc_e0", SET_CONFIG, 0);
        check("manual_busy", BUSY, 0);
        step();
        check("manual_sc_e1", SET_CONFIG, 1);
        check("manual_baseline_e1", H_GAIN_BASELINE, -200);
        step();
        check("manual_sc_e2", SET_CONFIG, 0);
        exp_sc++;

        for (int i = 0; i < 8; i++) calibrate(vecs[i]);

        // Reset lands on the 8th accumulated beat of a run.
        START = 1'b1;
        step();
        START = 1'b0;
        for (int bi = 0; bi < 12; bi++) begin
            H_S_AXIS_TVALID = 1'b1;
            H_S_AXIS_TDATA  = beat(12'sd500, 12'sd500, 4'h0);
            if (bi == 11) ARESET = 1'b1;
            step();
        end
        ARESET = 1'b0;
        H_S_AXIS_TVALID = 1'b0;
        check_reset_state("midreset");
        calibrate(vecs[0]);

        // Reset beats START and MANUAL_SET in the same cycle.
        ARESET = 1'b1; START = 1'b1; MANUAL_SET = 1'b1; MANUAL_BASELINE = 13'sd55;
        step();
        ARESET = 1'b0; START = 1'b0; MANUAL_SET = 1'b0;
        check("prio_busy", BUSY, 0);
        check("prio_baseline", H_GAIN_BASELINE, -1024);
        step();
        check("prio_no_sc", SET_CONFIG, 0);
        check("prio_busy2", BUSY, 0);

        step();
        check("sc_pulse_total", sc_count, exp_sc);
        check("sc_never_consecutive", sc_consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/baseline_calibrator.md
BASELINE_CALIBRATOR -- requirements
Module: baseline_calibrator

Interface
REQ-001 Parameter LOG2_ACC_BEATS, 4: log2 of the number of valid H-gain beats accumulated per calibration (16 beats, 128 samples).
REQ-002 Parameter FLUSH_CYCLES, 4: number of valid beats discarded before accumulation starts.
REQ-003 Parameter TIMEOUT_CYCLES, 1024: maximum consecutive clocks without H_S_AXIS_TVALID during FLUSH/ACCUM before abort.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  reset, synchronous, active-high.
REQ-006 START  in  1  one-cycle request to begin calibration; sampled only in IDLE.
REQ-007 MANUAL_SET  in  1  one-cycle request to load MANUAL_BASELINE directly; sampled only in IDLE.
REQ-008 MANUAL_BASELINE  in  ADC_RESOLUTION_WIDTH+1 (13), signed  baseline loaded on MANUAL_SET.
REQ-009 H_S_AXIS_TDATA  in  RFDC_TDATA_WIDTH (128)  H-gain ADC beat, SAMPLE_NUM_PER_CLK (8) lanes of SAMPLE_WIDTH (16) bits.
REQ-010 H_S_AXIS_TVALID  in  1  beat qualifier; there is no TREADY (the block only observes the stream).
REQ-011 SET_CONFIG  out  1  one-cycle config strobe to the DSP stage.
REQ-012 H_GAIN_BASELINE  out  13, signed  baseline presented to the DSP stage.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  sticky success flag.
REQ-015 CAL_ERROR  out  1  sticky timeout flag.

Function
REQ-016 Lane i sample = signed TDATA[i*16+4 +: 12]; bits [3:0] of each lane are ignored.
REQ-017 States: IDLE, FLUSH, ACCUM, COMPUTE, APPLY, ERROR.
REQ-018 IDLE: START=1 -> FLUSH; the beat counter, timeout counter and accumulator clear, and DONE and CAL_ERROR clear. If START and MANUAL_SET are both 1, START wins.
REQ-019 IDLE: MANUAL_SET=1 (and START=0) -> H_GAIN_BASELINE <= MANUAL_BASELINE on that edge, then SET_CONFIG=1 in the next cycle only; the state stays IDLE and BUSY stays 0.
REQ-020 FLUSH: each valid beat increments the beat counter; after the FLUSH_CYCLES-th valid beat -> ACCUM with the counter cleared.
REQ-021 ACCUM: each valid beat adds the sum of its 8 lane samples into a signed accumulator of 12+3+LOG2_ACC_BEATS bits (19 by default), which cannot overflow; after the 2^LOG2_ACC_BEATS-th beat -> COMPUTE.
REQ-022 COMPUTE, one cycle: H_GAIN_BASELINE <= accumulator arithmetically shifted right by 3+LOG2_ACC_BEATS (floor division), sign-extended to 13 bits; then -> APPLY.
REQ-023 APPLY, one cycle: SET_CONFIG=1 and DONE <= 1; then -> IDLE.
REQ-024 Latency: the final ACCUM beat is captured at edge N, H_GAIN_BASELINE updates at edge N+1, and SET_CONFIG is high for the cycle between edges N+2 and N+3.
REQ-025 The timeout counter resets on every valid beat and increments on every invalid cycle in FLUSH/ACCUM; reaching TIMEOUT_CYCLES -> ERROR.
REQ-026 ERROR, one cycle: CAL_ERROR <= 1, no SET_CONFIG, H_GAIN_BASELINE unchanged; then -> IDLE.
REQ-027 START and MANUAL_SET outside IDLE are ignored, not queued.
REQ-028 SET_CONFIG is never high for 2 consecutive cycles, and H_GAIN_BASELINE is stable whenever SET_CONFIG=1.

Reset
REQ-029 ARESET=1 on any edge, including mid-calibration, forces: state IDLE, SET_CONFIG 0, BUSY 0, DONE 0, CAL_ERROR 0, H_GAIN_BASELINE -1024, all counters and the accumulator 0.
REQ-030 ARESET has priority over START and MANUAL_SET in the same cycle.

Structure
REQ-031 ADC_RESOLUTION_WIDTH, SAMPLE_WIDTH, SAMPLE_NUM_PER_CLK, RFDC_TDATA_WIDTH and the reset baseline (-1024) come from the shared dsp_config header, with no local redefinition.
REQ-032 The state encoding is local to the module.
REQ-033 One sub-module, lane_sum: a combinational signed adder tree summing the 8 extracted 12-bit lanes to 15 bits, instantiated once.

Verification
REQ-034 Reset, then START with all lanes = 100 (lane word 0x0640) and TVALID always 1 -> one SET_CONFIG pulse 2 cycles after the 20th valid beat, with H_GAIN_BASELINE = 100 and DONE = 1.
REQ-035 Lanes alternating -3/-4 in ACCUM -> mean -3.5 -> H_GAIN_BASELINE = -4 (floor).
REQ-036 TVALID held 0 after START -> CAL_ERROR = 1 after 1024 cycles, no SET_CONFIG, H_GAIN_BASELINE stays -1024.
REQ-037 ARESET asserted at the 8th ACCUM beat -> next cycle all outputs at reset values; a subsequent START calibrates correctly (a fresh 4 flush + 16 accumulated beats).
REQ-038 MANUAL_SET with MANUAL_BASELINE = -200 in IDLE -> H_GAIN_BASELINE = -200 and a single SET_CONFIG pulse next cycle; MANUAL_SET during ACCUM -> no effect.
REQ-039 TVALID gaps of 3 cycles every beat -> the result is identical to REQ-034, with no timeout.
